// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between the main-pipeline WB stage and a long-latency result queue.
// Latency: 1 cycle from grant to rf_we/rf_waddr/rf_wdata; queue enqueue visible in q_count next cycle.
// Backpressure: pipe_stall (combinational) holds WB when the queue head wins; lu_ready=0 while the queue is full.
//
// Ports:
//   clk, rst_n                     rising-edge clock, asynchronous active-low reset
//   pipe_valid/pipe_rd/pipe_wdata  main-pipeline writeback request (rd==0 means no request)
//   pipe_stall                     WB stage must hold this cycle
//   lu_valid/lu_ready/lu_rd/lu_wdata  long-latency result handshake (rd==0 accepted and dropped)
//   rf_we/rf_waddr/rf_wdata        registered register-file write port
//   q_count                        current queue occupancy
//   perf_stall_cnt                 stall-cycle counter, only live when WB_ARB_PERF_EN is defined
//
// Optional feature: define WB_ARB_PERF_EN to build the wrapping stall-cycle counter;
// without it perf_stall_cnt is tied to 0 and no counter flops exist.
// FIFO_DEPTH must be 2 or 4; STARVE_MAX must be 1..15.

module wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_valid,
  input  logic [4:0]            pipe_rd,
  input  logic [DATA_WIDTH-1:0] pipe_wdata,
  output logic                  pipe_stall,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [4:0]            lu_rd,
  input  logic [DATA_WIDTH-1:0] lu_wdata,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [2:0]            q_count,
  output logic [31:0]           perf_stall_cnt
);

  // Depth is a power of two, so pointers wrap naturally modulo FIFO_DEPTH.
  localparam int         PW       = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam logic [2:0] DEPTH_C  = 3'(FIFO_DEPTH);
  localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

  logic [4:0]            r_q_rd   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_q_data [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [2:0]            r_count;
  logic [3:0]            r_starve;

  logic                  r_rf_we;
  logic [4:0]            r_rf_waddr;
  logic [DATA_WIDTH-1:0] r_rf_wdata;

  logic w_pipe_req;
  logic w_q_nonempty;
  logic w_q_full;
  logic w_q_win;
  logic w_pipe_win;
  logic w_enq;

  always_comb begin
    w_pipe_req   = pipe_valid && (pipe_rd != 5'd0);
    w_q_nonempty = (r_count != 3'd0);
    w_q_full     = (r_count == DEPTH_C);
    // Queue head takes the port when the pipe is idle, when the queue cannot
    // accept more results, or when it has been deferred long enough.
    w_q_win      = w_q_nonempty &&
                   (!w_pipe_req || w_q_full || (r_starve == STARVE_C));
    w_pipe_win   = w_pipe_req && !w_q_win;
    // No pass-through when full: a full queue refuses the result outright.
    w_enq        = lu_valid && !w_q_full && (lu_rd != 5'd0);
  end

  assign pipe_stall = w_pipe_req && w_q_win;
  assign lu_ready   = !w_q_full;
  assign q_count    = r_count;
  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;

  // Queue storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_rd[r_wr_ptr]   <= lu_rd;
      r_q_data[r_wr_ptr] <= lu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 3'd0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_q_win) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + 3'(w_enq) - 3'(w_q_win);
    end
  end

  // Deferral counter: only runs while a queued result is waiting behind the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 4'd0;
    end else if (!w_q_nonempty || w_q_win) begin
      r_starve <= 4'd0;
    end else if (r_starve != STARVE_C) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  // Write port: address/data hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_rf_wdata <= '0;
    end else if (w_q_win) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= r_q_rd[r_rd_ptr];
      r_rf_wdata <= r_q_data[r_rd_ptr];
    end else if (w_pipe_win) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= pipe_rd;
      r_rf_wdata <= pipe_wdata;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [31:0] r_perf_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall_cnt <= 32'd0;
    end else if (pipe_stall) begin
      r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule
